// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the Tower of Hanoi move generator.
//   peg_t             : peg number 0..2
//   PEG_SRC / PEG_DST : start and finish pegs of the tower
//   hanoi_gen_state_t : generator FSM states
//   mod3()            : combinational modulo-3 of a value of up to 16 bits
//   map_peg()         : swaps pegs 1 and 2 when the disk count is even
package hanoi_pkg;

    typedef logic [1:0] peg_t;

    localparam peg_t PEG_SRC = 2'd0;
    localparam peg_t PEG_DST = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } hanoi_gen_state_t;

    // 2^i mod 3 alternates 1,2,1,2... so the weighted bit sum is congruent to
    // the value. The sum (<= 32) is then folded in 2-bit digits, since
    // 4 mod 3 == 1, until it is at most 3; a final 3 maps to 0.
    function automatic logic [1:0] mod3(input logic [15:0] value, input int width);
        logic [5:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width && value[i])
                acc = acc + ((i % 2 == 1) ? 6'd2 : 6'd1);
        end
        acc = 6'(acc[1:0]) + 6'(acc[3:2]) + 6'(acc[5:4]);
        acc = 6'(acc[1:0]) + 6'(acc[3:2]);
        acc = 6'(acc[1:0]) + 6'(acc[3:2]);
        return (acc[1:0] == 2'd3) ? 2'd0 : acc[1:0];
    endfunction

    function automatic peg_t map_peg(input peg_t p, input logic even);
        if (even && p == 2'd1) return 2'd2;
        if (even && p == 2'd2) return 2'd1;
        return p;
    endfunction

endpackage

// File: rtl/hanoi_move_calc.sv
// Combinational peg calculation for move number m of an S-disk solve.
//   m  : move counter, S+1 bits (the top bit absorbs (m | (m-1)) + 1)
//   fr : source peg
//   to : destination peg
// The raw formula moves the tower to peg 2 when S is odd and to peg 1 when S
// is even, so pegs 1 and 2 are swapped for even S.
module hanoi_move_calc
    import hanoi_pkg::*;
#(
    parameter int S = 3
) (
    input  logic [S:0] m,
    output logic [1:0] fr,
    output logic [1:0] to
);

    localparam logic EVEN_S = (S % 2 == 0);

    logic [S:0] lo;
    logic [S:0] hi;
    peg_t       fr_r;
    peg_t       to_r;

    always_comb begin
        lo   = m & (m - 1'b1);
        hi   = (m | (m - 1'b1)) + 1'b1;
        fr_r = mod3(16'(lo), S + 1);
        to_r = mod3(16'(hi), S + 1);
        fr   = map_peg(fr_r, EVEN_S);
        to   = map_peg(to_r, EVEN_S);
    end

endmodule

// File: rtl/hanoi_move_gen.sv
// Tower of Hanoi move generator. On start it presents the optimal 2^S-1
// moves (peg 0 -> peg 2) one at a time over a valid/ready handshake.
//   clk, rst (sync, active low)
//   start    : begin a solve, sampled in IDLE only
//   mv_valid : fr/to/mv_idx hold a move
//   mv_ready : consumer takes the move
//   fr, to   : source / destination peg
//   mv_idx   : 1-based move number, 0 outside RUN
//   busy     : solve in progress
//   done     : one-cycle pulse after the last move transfers
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int S = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         mv_valid,
    input  logic         mv_ready,
    output logic [1:0]   fr,
    output logic [1:0]   to,
    output logic [S-1:0] mv_idx,
    output logic         busy,
    output logic         done
);

    localparam logic [S:0] LAST_M = {1'b0, {S{1'b1}}};
    localparam logic [S:0] FIRST_M = {{S{1'b0}}, 1'b1};

    hanoi_gen_state_t state_q, state_d;
    logic [S:0]       m_q, m_d;
    logic [1:0]       calc_fr;
    logic [1:0]       calc_to;

    hanoi_move_calc #(.S(S)) u_calc (
        .m  (m_q),
        .fr (calc_fr),
        .to (calc_to)
    );

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        mv_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        fr       = '0;
        to       = '0;
        mv_idx   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = FIRST_M;
                end
            end
            RUN: begin
                mv_valid = 1'b1;
                busy     = 1'b1;
                fr       = calc_fr;
                to       = calc_to;
                mv_idx   = m_q[S-1:0];
                if (mv_ready) begin
                    if (m_q == LAST_M) begin
                        state_d = DONE;
                        m_d     = '0;
                    end else begin
                        m_d = m_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
        end
    end

endmodule
